// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NREQ requesters,
// with a single registered result slot tagged by the issuing requester's id.

module alu #(
  parameter int XLEN = 32
) (
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] rd,
  output logic            zero
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [4:0] ALU_ADD  = 5'h00;
  localparam logic [4:0] ALU_SUB  = 5'h01;
  localparam logic [4:0] ALU_AND  = 5'h02;
  localparam logic [4:0] ALU_OR   = 5'h03;
  localparam logic [4:0] ALU_XOR  = 5'h04;
  localparam logic [4:0] ALU_SLL  = 5'h05;
  localparam logic [4:0] ALU_SRL  = 5'h06;
  localparam logic [4:0] ALU_SRA  = 5'h07;
  localparam logic [4:0] ALU_SLT  = 5'h08;
  localparam logic [4:0] ALU_SLTU = 5'h09;

  logic [SHW-1:0] shamt;

  assign shamt = b[SHW-1:0];

  // Any opcode outside the table yields all-ones so a bad op is visible downstream.
  always_comb begin
    rd = '1;
    case (op)
      ALU_ADD:  rd = a + b;
      ALU_SUB:  rd = a - b;
      ALU_AND:  rd = a & b;
      ALU_OR:   rd = a | b;
      ALU_XOR:  rd = a ^ b;
      ALU_SLL:  rd = a << shamt;
      ALU_SRL:  rd = a >> shamt;
      ALU_SRA:  rd = $signed(a) >>> shamt;
      ALU_SLT:  rd = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: rd = {{(XLEN-1){1'b0}}, (a < b)};
      default:  rd = '1;
    endcase
  end

  assign zero = (rd == '0);

endmodule

module alu_arbiter #(
  parameter int XLEN = 32,
  parameter int NREQ = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*5-1:0]        req_opcode,
  input  logic [NREQ*XLEN-1:0]     req_rs1,
  input  logic [NREQ*XLEN-1:0]     req_rs2,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [$clog2(NREQ)-1:0]  resp_id,
  output logic [XLEN-1:0]          resp_rd,
  output logic                     resp_zero,
  output logic [15:0]              busy_cnt
);

  localparam int IDW = $clog2(NREQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic            resp_valid_q, resp_valid_d;
  logic [IDW-1:0]  resp_id_q, resp_id_d;
  logic [XLEN-1:0] resp_rd_q, resp_rd_d;
  logic            resp_zero_q, resp_zero_d;
  logic [15:0]     busy_cnt_q, busy_cnt_d;

  logic            grant_found;
  logic [IDW-1:0]  grant_idx;
  logic [IDW-1:0]  scan_idx;
  logic            slot_free;
  logic            accept;
  logic [4:0]      alu_op;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_rd;
  logic            alu_zero;

  // Scan from rr_ptr upward with explicit wrap so non-power-of-2 NREQ stays in range.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = rr_ptr_q;
    scan_idx    = rr_ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
      scan_idx = (scan_idx == LAST_ID) ? '0 : scan_idx + IDW'(1);
    end
  end

  assign slot_free = !resp_valid_q || resp_ready;
  assign accept    = grant_found && slot_free && !rst;

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready = NREQ'(1) << grant_idx;
    end
  end

  assign alu_op = req_opcode[int'(grant_idx)*5 +: 5];
  assign alu_a  = req_rs1[int'(grant_idx)*XLEN +: XLEN];
  assign alu_b  = req_rs2[int'(grant_idx)*XLEN +: XLEN];

  alu #(
    .XLEN (XLEN)
  ) u_alu (
    .op   (alu_op),
    .a    (alu_a),
    .b    (alu_b),
    .rd   (alu_rd),
    .zero (alu_zero)
  );

  // The slot refills on the same edge it drains, giving one op per cycle.
  always_comb begin
    resp_valid_d = accept || (resp_valid_q && !resp_ready);
    resp_id_d    = resp_id_q;
    resp_rd_d    = resp_rd_q;
    resp_zero_d  = resp_zero_q;
    rr_ptr_d     = rr_ptr_q;
    busy_cnt_d   = busy_cnt_q;
    if (accept) begin
      resp_id_d   = grant_idx;
      resp_rd_d   = alu_rd;
      resp_zero_d = alu_zero;
      rr_ptr_d    = (grant_idx == LAST_ID) ? '0 : grant_idx + IDW'(1);
      if (busy_cnt_q != 16'hFFFF) begin
        busy_cnt_d = busy_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_rd_q    <= '0;
      resp_zero_q  <= 1'b0;
      busy_cnt_q   <= 16'd0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_rd_q    <= resp_rd_d;
      resp_zero_q  <= resp_zero_d;
      busy_cnt_q   <= busy_cnt_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_rd    = resp_rd_q;
  assign resp_zero  = resp_zero_q;
  assign busy_cnt   = busy_cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, hand-written backpressure,
// reset and saturation sequences, then random traffic against a reference model.

module tb_alu_arbiter;

  localparam int XLEN = 32;
  localparam int NREQ = 2;

  localparam logic [4:0] OP_ADD  = 5'h00;
  localparam logic [4:0] OP_SUB  = 5'h01;
  localparam logic [4:0] OP_AND  = 5'h02;
  localparam logic [4:0] OP_OR   = 5'h03;
  localparam logic [4:0] OP_XOR  = 5'h04;
  localparam logic [4:0] OP_SLL  = 5'h05;
  localparam logic [4:0] OP_SRL  = 5'h06;
  localparam logic [4:0] OP_SRA  = 5'h07;
  localparam logic [4:0] OP_SLT  = 5'h08;
  localparam logic [4:0] OP_SLTU = 5'h09;
  localparam logic [4:0] OP_BAD  = 5'h1F;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*5-1:0]    req_opcode;
  logic [NREQ*XLEN-1:0] req_rs1;
  logic [NREQ*XLEN-1:0] req_rs2;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [0:0]           resp_id;
  logic [XLEN-1:0]      resp_rd;
  logic                 resp_zero;
  logic [15:0]          busy_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: the result slot, the fairness pointer and the op counter.
  bit          m_valid;
  int          m_id;
  logic [31:0] m_rd;
  bit          m_zero;
  int          m_ptr;
  int          m_cnt;
  int          m_grant;

  typedef struct {
    logic [1:0]  v;
    logic [4:0]  op0;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [4:0]  op1;
    logic [31:0] a1;
    logic [31:0] b1;
    logic        rr;
    logic [1:0]  expReady;
    logic        expValid;
    logic        expId;
    logic [31:0] expRd;
    logic        expZero;
    logic [15:0] expCnt;
  } vec_t;

  vec_t tbl[10];

  alu_arbiter #(
    .XLEN (XLEN),
    .NREQ (NREQ)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_rd    (resp_rd),
    .resp_zero  (resp_zero),
    .busy_cnt   (busy_cnt)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Arithmetic written from the opcode meanings rather than the RTL's datapath.
  function automatic logic [31:0] refAlu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned s;
    s = int'(b[4:0]);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << s;
      OP_SRL:  return a >> s;
      OP_SRA:  return a[31] ? ~((~a) >> s) : (a >> s);
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    m_valid = 1'b0;
    m_id    = 0;
    m_rd    = 32'd0;
    m_zero  = 1'b0;
    m_ptr   = 0;
    m_cnt   = 0;
    m_grant = -1;
  endtask

  // Pick the first valid requester starting at the pointer, only if the slot can take a result.
  task automatic modelArbitrate();
    m_grant = -1;
    if (!m_valid || resp_ready) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (m_grant < 0 && req_valid[i]) m_grant = i;
      end
    end
  endtask

  task automatic modelEdge();
    if (m_grant >= 0) begin
      m_rd    = refAlu(req_opcode[m_grant*5 +: 5], req_rs1[m_grant*XLEN +: XLEN], req_rs2[m_grant*XLEN +: XLEN]);
      m_zero  = (m_rd == 32'd0);
      m_id    = m_grant;
      m_valid = 1'b1;
      m_ptr   = (m_grant + 1) % NREQ;
      if (m_cnt < 65535) m_cnt++;
    end else if (m_valid && resp_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "_resp_valid"}, 32'(resp_valid), 32'(m_valid));
    checkOutput({tag, "_resp_id"},    32'(resp_id),    32'(m_id));
    checkOutput({tag, "_resp_rd"},    resp_rd,         m_rd);
    checkOutput({tag, "_resp_zero"},  32'(resp_zero),  32'(m_zero));
    checkOutput({tag, "_busy_cnt"},   32'(busy_cnt),   32'(m_cnt));
  endtask

  // Drive one cycle of inputs just after an edge, sample req_ready mid-cycle, then step past the edge.
  task automatic applyStimulus(input logic [1:0] v, input logic [4:0] op0, input logic [31:0] a0,
                               input logic [31:0] b0, input logic [4:0] op1, input logic [31:0] a1,
                               input logic [31:0] b1, input logic rr, input bit useModel,
                               output logic [1:0] readySeen);
    logic [1:0] expReady;
    req_valid  = v;
    req_opcode = {op1, op0};
    req_rs1    = {a1, a0};
    req_rs2    = {b1, b0};
    resp_ready = rr;
    #1;
    readySeen = req_ready;
    modelArbitrate();
    expReady = (m_grant >= 0) ? 2'(1 << m_grant) : 2'b00;
    if (useModel) checkOutput("req_ready", 32'(req_ready), 32'(expReady));
    @(posedge clk);
    #1;
    modelEdge();
    if (useModel) checkModel("model");
  endtask

  initial begin
    logic [1:0]  rs;
    bit          pend[NREQ];
    logic [4:0]  pOp[NREQ];
    logic [31:0] pA[NREQ];
    logic [31:0] pB[NREQ];
    logic [31:0] specials[4];

    specials[0] = 32'h0000_0000;
    specials[1] = 32'h8000_0000;
    specials[2] = 32'hFFFF_FFFF;
    specials[3] = 32'h0000_0001;

    // Directed vectors: fairness, single op and the operator corner cases.
    tbl[0] = '{2'b11, OP_SUB, 32'd3, 32'd3, OP_XOR, 32'd1, 32'd2, 1'b1, 2'b01, 1'b1, 1'b0, 32'd0, 1'b1, 16'd1};
    tbl[1] = '{2'b11, OP_SUB, 32'd3, 32'd3, OP_XOR, 32'd1, 32'd2, 1'b1, 2'b10, 1'b1, 1'b1, 32'd3, 1'b0, 16'd2};
    tbl[2] = '{2'b11, OP_SUB, 32'd3, 32'd3, OP_XOR, 32'd1, 32'd2, 1'b1, 2'b01, 1'b1, 1'b0, 32'd0, 1'b1, 16'd3};
    tbl[3] = '{2'b11, OP_SUB, 32'd3, 32'd3, OP_XOR, 32'd1, 32'd2, 1'b1, 2'b10, 1'b1, 1'b1, 32'd3, 1'b0, 16'd4};
    tbl[4] = '{2'b01, OP_ADD, 32'd5, 32'd7, OP_ADD, 32'd0, 32'd0, 1'b1, 2'b01, 1'b1, 1'b0, 32'd12, 1'b0, 16'd5};
    tbl[5] = '{2'b10, OP_ADD, 32'd0, 32'd0, OP_SRA, 32'h8000_0000, 32'd4, 1'b1, 2'b10, 1'b1, 1'b1, 32'hF800_0000, 1'b0, 16'd6};
    tbl[6] = '{2'b10, OP_ADD, 32'd0, 32'd0, OP_SLTU, 32'd1, 32'hFFFF_FFFF, 1'b1, 2'b10, 1'b1, 1'b1, 32'd1, 1'b0, 16'd7};
    tbl[7] = '{2'b10, OP_ADD, 32'd0, 32'd0, OP_SLT, 32'd1, 32'hFFFF_FFFF, 1'b1, 2'b10, 1'b1, 1'b1, 32'd0, 1'b1, 16'd8};
    tbl[8] = '{2'b10, OP_ADD, 32'd0, 32'd0, OP_BAD, 32'd0, 32'd0, 1'b1, 2'b10, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 16'd9};
    tbl[9] = '{2'b00, OP_ADD, 32'd0, 32'd0, OP_ADD, 32'd0, 32'd0, 1'b1, 2'b00, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 16'd9};

    rst        = 1'b1;
    req_valid  = '0;
    req_opcode = '0;
    req_rs1    = '0;
    req_rs2    = '0;
    resp_ready = 1'b0;
    modelReset();

    // Reset values, then release reset away from the clock edge.
    repeat (2) @(posedge clk);
    #1;
    checkModel("reset");
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(tbl[i].v, tbl[i].op0, tbl[i].a0, tbl[i].b0, tbl[i].op1, tbl[i].a1, tbl[i].b1,
                    tbl[i].rr, 1'b0, rs);
      checkOutput($sformatf("tbl%0d_req_ready", i),  32'(rs),         32'(tbl[i].expReady));
      checkOutput($sformatf("tbl%0d_resp_valid", i), 32'(resp_valid), 32'(tbl[i].expValid));
      checkOutput($sformatf("tbl%0d_resp_id", i),    32'(resp_id),    32'(tbl[i].expId));
      checkOutput($sformatf("tbl%0d_resp_rd", i),    resp_rd,         tbl[i].expRd);
      checkOutput($sformatf("tbl%0d_resp_zero", i),  32'(resp_zero),  32'(tbl[i].expZero));
      checkOutput($sformatf("tbl%0d_busy_cnt", i),   32'(busy_cnt),   32'(tbl[i].expCnt));
    end

    // Backpressure: fill the slot, stall three cycles, then drain and refill on one edge.
    applyStimulus(2'b01, OP_ADD, 32'd2, 32'd3, OP_XOR, 32'd0, 32'd0, 1'b0, 1'b1, rs);
    checkOutput("bp_accept_ready", 32'(rs), 32'h1);
    checkOutput("bp_accept_rd", resp_rd, 32'd5);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b11, OP_SUB, 32'd9, 32'd4, OP_XOR, 32'd6, 32'd2, 1'b0, 1'b1, rs);
      checkOutput("bp_stall_ready", 32'(rs), 32'h0);
      checkOutput("bp_stall_valid", 32'(resp_valid), 32'h1);
      checkOutput("bp_stall_rd", resp_rd, 32'd5);
      checkOutput("bp_stall_id", 32'(resp_id), 32'h0);
    end
    applyStimulus(2'b11, OP_SUB, 32'd9, 32'd4, OP_XOR, 32'd6, 32'd2, 1'b1, 1'b1, rs);
    checkOutput("bp_release_ready", 32'(rs), 32'h2);
    checkOutput("bp_release_valid", 32'(resp_valid), 32'h1);
    checkOutput("bp_release_rd", resp_rd, 32'd4);
    checkOutput("bp_release_id", 32'(resp_id), 32'h1);

    // Asynchronous reset mid-cycle with a result pending and requests waiting.
    req_valid  = 2'b11;
    resp_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_async_valid", 32'(resp_valid), 32'h0);
    checkOutput("rst_async_id",    32'(resp_id),    32'h0);
    checkOutput("rst_async_rd",    resp_rd,         32'h0);
    checkOutput("rst_async_zero",  32'(resp_zero),  32'h0);
    checkOutput("rst_async_cnt",   32'(busy_cnt),   32'h0);
    checkOutput("rst_async_ready", 32'(req_ready),  32'h0);
    @(posedge clk);
    #1;
    checkOutput("rst_hold_ready", 32'(req_ready),  32'h0);
    checkOutput("rst_hold_valid", 32'(resp_valid), 32'h0);
    checkOutput("rst_hold_cnt",   32'(busy_cnt),   32'h0);
    req_valid = 2'b00;
    #2;
    rst = 1'b0;
    modelReset();
    @(posedge clk);
    #1;

    // Random traffic; each requester holds its op until it is accepted.
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0;
      pOp[i]  = OP_ADD;
      pA[i]   = 32'd0;
      pB[i]   = 32'd0;
    end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          pOp[i]  = ($urandom_range(0, 7) == 0) ? OP_BAD : 5'($urandom_range(0, 12));
          pA[i]   = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
          pB[i]   = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
        end
      end
      applyStimulus({pend[1], pend[0]}, pOp[0], pA[0], pB[0], pOp[1], pA[1], pB[1],
                    ($urandom_range(0, 3) != 0), 1'b1, rs);
      for (int i = 0; i < NREQ; i++) begin
        if (rs[i]) pend[i] = 1'b0;
      end
    end

    // Counter saturation: preload near the top, then issue ops past it.
    force dut.busy_cnt_q = 16'hFFFE;
    #1;
    release dut.busy_cnt_q;
    m_cnt = 65534;
    applyStimulus(2'b01, OP_ADD, 32'd1, 32'd1, OP_ADD, 32'd0, 32'd0, 1'b1, 1'b1, rs);
    checkOutput("sat_first", 32'(busy_cnt), 32'h0000_FFFF);
    applyStimulus(2'b01, OP_ADD, 32'd1, 32'd2, OP_ADD, 32'd0, 32'd0, 1'b1, 1'b1, rs);
    checkOutput("sat_second", 32'(busy_cnt), 32'h0000_FFFF);
    applyStimulus(2'b10, OP_ADD, 32'd0, 32'd0, OP_ADD, 32'd4, 32'd4, 1'b1, 1'b1, rs);
    checkOutput("sat_third", 32'(busy_cnt), 32'h0000_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
